// File: rtl/fifo_input_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among four byte producers.
// Grants are bounded bursts; priority rotates past the last granted producer.
module fifo_input_arbiter #(
    parameter int BURST_MAX = 16
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [31:0] reqData_in,
    input  logic [3:0]  reqValid_in,
    output logic [3:0]  reqReady_out,
    output logic [7:0]  outputData_out,
    output logic        outputValid_out,
    input  logic        outputReady_in,
    output logic [1:0]  grant_out,
    output logic        busy_out,
    output logic [7:0]  burstCount_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(BURST_MAX - 1);

    state_t      state;
    logic [1:0]  last_grant;
    logic [1:0]  next_grant;
    logic [1:0]  cand;
    logic        found;
    logic        sel_valid;
    logic [7:0]  sel_data;

    // Scan starts one past the last granted producer so nobody is starved.
    always_comb begin
        next_grant = last_grant;
        found      = 1'b0;
        cand       = last_grant;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && reqValid_in[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    assign busy_out  = (state == BURST);
    assign sel_valid = reqValid_in[grant_out];
    assign sel_data  = reqData_in[{grant_out, 3'b000} +: 8];

    // Zero-latency path from the granted producer straight to the FIFO.
    always_comb begin
        outputValid_out = busy_out & sel_valid;
        outputData_out  = busy_out ? sel_data : 8'h00;
        reqReady_out    = (busy_out && outputReady_in) ? (4'b0001 << grant_out) : 4'b0000;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= IDLE;
            grant_out      <= 2'd0;
            last_grant     <= 2'd3;
            burstCount_out <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|reqValid_in) begin
                        grant_out      <= next_grant;
                        burstCount_out <= 8'd0;
                        state          <= BURST;
                    end
                end
                BURST: begin
                    if (!sel_valid) begin
                        state          <= IDLE;
                        last_grant     <= grant_out;
                        burstCount_out <= 8'd0;
                    end else if (outputReady_in) begin
                        if (burstCount_out == LAST_COUNT) begin
                            state          <= IDLE;
                            last_grant     <= grant_out;
                            burstCount_out <= 8'd0;
                        end else begin
                            burstCount_out <= burstCount_out + 8'd1;
                        end
                    end
                    // Valid with FIFO full: hold everything until it drains.
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_input_arbiter.sv
// Scoreboard bench for fifo_input_arbiter: directed bursts plus a random soak.
module tb_fifo_input_arbiter;

    localparam int BM = 4;

    logic        clk = 1'b0;
    logic        reset_n_in;
    logic [31:0] reqData_in;
    logic [3:0]  reqValid_in;
    logic [3:0]  reqReady_out;
    logic [7:0]  outputData_out;
    logic        outputValid_out;
    logic        outputReady_in;
    logic [1:0]  grant_out;
    logic        busy_out;
    logic [7:0]  burstCount_out;

    fifo_input_arbiter #(.BURST_MAX(BM)) dut (
        .clk_in          (clk),
        .reset_n_in      (reset_n_in),
        .reqData_in      (reqData_in),
        .reqValid_in     (reqValid_in),
        .reqReady_out    (reqReady_out),
        .outputData_out  (outputData_out),
        .outputValid_out (outputValid_out),
        .outputReady_in  (outputReady_in),
        .grant_out       (grant_out),
        .busy_out        (busy_out),
        .burstCount_out  (burstCount_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] grant;
        logic [7:0] count;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         mode  = 0;      // 0 directed scoreboard, 1 soak, 2 off
    logic [5:0] seq[4];
    logic [3:0] accepted = 4'b0000;
    int         run_len  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] g, input logic [7:0] c);
        exp_t e;
        e.data  = d;
        e.grant = g;
        e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reqValid_in    = 4'b0000;
        reqData_in     = 32'h0;
        outputReady_in = 1'b1;
        reset_n_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n_in = 1'b1;
    endtask

    // Monitor: pops one expectation per FIFO write, checks soak invariants.
    always @(negedge clk) begin
        exp_t e;
        if (mode == 0 && outputValid_out && outputReady_in) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer actual=%h required=none", outputData_out);
            end else begin
                e = exp_q.pop_front();
                check("sb_data",  32'(outputData_out), 32'(e.data));
                check("sb_grant", 32'(grant_out),      32'(e.grant));
                check("sb_count", 32'(burstCount_out), 32'(e.count));
            end
        end else if (mode == 1) begin
            accepted = reqReady_out & reqValid_in;
            check("soak_ready_onehot", 32'($onehot0(reqReady_out)), 32'd1);
            if (!busy_out) run_len = 0;
            if (outputValid_out && outputReady_in) begin
                run_len++;
                check("soak_ready_bit", 32'(reqReady_out), 32'(4'b0001 << grant_out));
                check("soak_data", 32'(outputData_out), 32'({grant_out, seq[grant_out]}));
                check("soak_count", 32'(burstCount_out), 32'(run_len - 1));
                check("soak_burst_len", 32'(run_len <= BM), 32'd1);
            end
        end
    end

    initial begin
        reset_n_in     = 1'b0;
        reqValid_in    = 4'b0000;
        reqData_in     = 32'h0;
        outputReady_in = 1'b1;
        for (int n = 0; n < 4; n++) seq[n] = 6'd0;

        // Reset values while reset is held and requests are present.
        #3;
        reqValid_in = 4'b1111;
        #1;
        check("rst_busy",  32'(busy_out),        32'd0);
        check("rst_grant", 32'(grant_out),       32'd0);
        check("rst_count", 32'(burstCount_out),  32'd0);
        check("rst_valid", 32'(outputValid_out), 32'd0);
        check("rst_ready", 32'(reqReady_out),    32'd0);
        check("rst_data",  32'(outputData_out),  32'd0);

        // Single producer 0: two full bursts separated by one idle cycle.
        do_reset();
        reqData_in  = 32'h0000_00A5;
        reqValid_in = 4'b0001;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < BM; k++) push(8'hA5, 2'd0, 8'(k));
        tick();
        check("t1_busy",  32'(busy_out),        32'd1);
        check("t1_grant", 32'(grant_out),       32'd0);
        check("t1_valid", 32'(outputValid_out), 32'd1);
        check("t1_ready", 32'(reqReady_out),    32'b0001);
        repeat (BM) tick();
        check("t1_gap_busy",  32'(busy_out),        32'd0);
        check("t1_gap_valid", 32'(outputValid_out), 32'd0);
        tick();
        check("t1_regrant_busy",  32'(busy_out),  32'd1);
        check("t1_regrant_grant", 32'(grant_out), 32'd0);
        repeat (BM) tick();
        reqValid_in = 4'b0000;
        tick();
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // All four producers: rotation 0,1,2,3,0 with full bursts.
        do_reset();
        reqData_in  = 32'h4030_2010;
        reqValid_in = 4'b1111;
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < BM; k++) push(8'((b % 4 + 1) * 16), 2'(b % 4), 8'(k));
        repeat (5 * (BM + 1)) tick();
        reqValid_in = 4'b0000;
        tick();
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Producer 2 with a 5-cycle FIFO stall in the middle of the burst.
        do_reset();
        reqValid_in = 4'b0100;
        reqData_in  = 32'h00C0_0000;
        for (int k = 0; k < BM; k++) push(8'(8'hC0 + k), 2'd2, 8'(k));
        tick();
        for (int k = 0; k < BM; k++) begin
            reqData_in = {8'h00, 8'(8'hC0 + k), 16'h0000};
            if (k == 2) begin
                outputReady_in = 1'b0;
                repeat (5) begin
                    tick();
                    check("t3_stall_valid", 32'(outputValid_out), 32'd1);
                    check("t3_stall_data",  32'(outputData_out),  32'hC2);
                    check("t3_stall_count", 32'(burstCount_out),  32'd2);
                end
                outputReady_in = 1'b1;
            end
            tick();
        end
        reqValid_in = 4'b0000;
        tick();
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Producer 1 runs dry after 3 bytes; producer 3 is granted next.
        do_reset();
        reqData_in  = 32'h7300_5100;
        reqValid_in = 4'b1010;
        for (int k = 0; k < 3; k++)  push(8'h51, 2'd1, 8'(k));
        for (int k = 0; k < BM; k++) push(8'h73, 2'd3, 8'(k));
        repeat (4) tick();
        reqValid_in = 4'b1000;
        tick();
        check("t4_dry_busy",  32'(busy_out),       32'd0);
        check("t4_dry_count", 32'(burstCount_out), 32'd0);
        check("t4_dry_grant", 32'(grant_out),      32'd1);
        tick();
        check("t4_next_grant", 32'(grant_out), 32'd3);
        reqValid_in = 4'b1010;
        #1;
        check("t4_nongrant_ready", 32'(reqReady_out), 32'b1000);
        repeat (5) tick();
        check("t4_regrant1", 32'(grant_out), 32'd1);
        check("t4_regrant1_busy", 32'(busy_out), 32'd1);
        reqValid_in = 4'b0000;
        tick();
        check("t4_end_busy", 32'(busy_out), 32'd0);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-burst, then producers 0 and 2 compete.
        do_reset();
        reqData_in  = 32'h0000_005E;
        reqValid_in = 4'b0001;
        push(8'h5E, 2'd0, 8'd0);
        tick();
        tick();
        #2;
        reset_n_in = 1'b0;
        #1;
        check("t5_async_valid", 32'(outputValid_out), 32'd0);
        check("t5_async_ready", 32'(reqReady_out),    32'd0);
        check("t5_async_busy",  32'(busy_out),        32'd0);
        check("t5_async_count", 32'(burstCount_out),  32'd0);
        reqValid_in = 4'b0101;
        reqData_in  = 32'h002A_000A;
        tick();
        check("t5_held_busy", 32'(busy_out), 32'd0);
        reset_n_in = 1'b1;
        for (int k = 0; k < BM; k++) push(8'h0A, 2'd0, 8'(k));
        for (int k = 0; k < BM; k++) push(8'h2A, 2'd2, 8'(k));
        tick();
        check("t5_first_grant", 32'(grant_out), 32'd0);
        repeat (2 * BM + 1) tick();
        reqValid_in = 4'b0000;
        tick();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Random valid/ready soak with per-producer sequence numbers.
        do_reset();
        accepted = 4'b0000;
        run_len  = 0;
        mode     = 1;
        for (int c = 0; c < 10000; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (accepted[n]) seq[n] = seq[n] + 6'd1;
                if ($urandom_range(0, 7) == 0) reqValid_in[n] = ~reqValid_in[n];
                reqData_in[8*n +: 8] = {2'(n), seq[n]};
            end
            outputReady_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        mode = 2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
